// File: rtl/imsic_msi_queue.sv
// IMSIC MSI front end: decodes seteipnum writes (little- and big-endian) for each
// interrupt file page and queues the identities in per-file FIFOs drained by valid/ready.
module imsic_msi_queue #(
    parameter int          NR_SRC        = 64,
    parameter int          NR_SRC_LEN    = $clog2(NR_SRC),
    parameter int          NR_INTP_FILES = 2,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] M_BASE        = 32'h24000000,
    parameter logic [31:0] S_BASE        = 32'h28000000,
    parameter logic [31:0] FILE_STRIDE   = 32'h1000,
    parameter int          ADDR_WIDTH    = 64
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_en,
    input  logic                                  i_we,
    input  logic [ADDR_WIDTH-1:0]                 i_addr,
    input  logic [7:0]                            i_be,
    input  logic [63:0]                           i_wdata,
    output logic [63:0]                           o_rdata,
    output logic                                  o_err,
    output logic [NR_INTP_FILES*NR_SRC_LEN-1:0]   o_setipnum,
    output logic [NR_INTP_FILES-1:0]              o_setipnum_valid,
    input  logic [NR_INTP_FILES-1:0]              i_setipnum_ready,
    output logic [NR_INTP_FILES-1:0]              o_overflow,
    input  logic [NR_INTP_FILES-1:0]              i_ovf_clr
);
    // Handshake: an entry transfers on a cycle where o_setipnum_valid[k] and
    // i_setipnum_ready[k] are both high at the rising edge; ready is ignored while empty.

    localparam int FW = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr32;
    logic          hit;
    logic [FW-1:0] hit_file;
    logic [31:0]   off;
    logic [31:0]   word;
    logic [31:0]   id_word;
    logic          be_ok;
    logic          accept;
    logic          unused_addr_bits;

    assign addr32           = i_addr[31:0];
    assign unused_addr_bits = ^i_addr[ADDR_WIDTH-1:32];

    always_comb begin
        logic [31:0] base;
        hit      = 1'b0;
        hit_file = '0;
        off      = '0;
        base     = '0;
        for (int k = 0; k < NR_INTP_FILES; k++) begin
            base = (k == 0) ? M_BASE : S_BASE + 32'(k - 1) * FILE_STRIDE;
            if (!hit && addr32 >= base && (addr32 - base) < FILE_STRIDE) begin
                hit      = 1'b1;
                hit_file = FW'(k);
                off      = addr32 - base;
            end
        end
    end

    assign word    = addr32[2] ? i_wdata[63:32] : i_wdata[31:0];
    assign be_ok   = addr32[2] ? (&i_be[7:4]) : (&i_be[3:0]);
    // The big-endian alias presents the identity byte-reversed.
    assign id_word = (off == 32'h4) ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    assign accept  = i_en && i_we && hit && (off == 32'h0 || off == 32'h4) && be_ok
                     && (id_word != 32'h0) && (id_word < 32'(NR_SRC));

    assign o_rdata = '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) o_err <= 1'b0;
        else       o_err <= i_en && !hit;
    end

    for (genvar g = 0; g < NR_INTP_FILES; g++) begin : g_file
        logic [NR_SRC_LEN-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]         rptr;
        logic [PW-1:0]         wptr;
        logic [CW-1:0]         count;
        logic                  ovf_q;
        logic                  push;
        logic                  pop;
        logic                  full;
        logic                  push_ok;

        assign push    = accept && (hit_file == FW'(g));
        assign pop     = (count != '0) && i_setipnum_ready[g];
        assign full    = (count == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
        assign push_ok = push && (!full || pop);

        always_ff @(posedge i_clk) begin
            if (!i_rst && push_ok) mem[wptr] <= id_word[NR_SRC_LEN-1:0];
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (push_ok) wptr <= wptr + PW'(1);
                if (pop)     rptr <= rptr + PW'(1);
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (push && !push_ok) ovf_q <= 1'b1;
                else if (i_ovf_clr[g]) ovf_q <= 1'b0;
            end
        end

        assign o_setipnum_valid[g]                      = (count != '0);
        assign o_setipnum[g*NR_SRC_LEN +: NR_SRC_LEN]   = (count != '0) ? mem[rptr] : '0;
        assign o_overflow[g]                            = ovf_q;
    end

endmodule

// File: tb/tb_imsic_msi_queue.sv
// Bench for imsic_msi_queue (4 files, depth 4): directed scenarios plus random
// traffic compared against a queue-based model of the MSI decode and FIFO rules.
module tb_imsic_msi_queue;
    localparam int NF = 4;
    localparam int L  = 6;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          we = 1'b0;
    logic [63:0]   addr = '0;
    logic [7:0]    be = '0;
    logic [63:0]   wdata = '0;
    logic [63:0]   rdata;
    logic          err;
    logic [NF*L-1:0] setipnum;
    logic [NF-1:0] valid;
    logic [NF-1:0] ready = '0;
    logic [NF-1:0] overflow;
    logic [NF-1:0] ovf_clr = '0;

    always #5 clk = ~clk;

    imsic_msi_queue #(.NR_SRC(64), .NR_INTP_FILES(NF), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_addr(addr), .i_be(be),
        .i_wdata(wdata), .o_rdata(rdata), .o_err(err), .o_setipnum(setipnum),
        .o_setipnum_valid(valid), .i_setipnum_ready(ready), .o_overflow(overflow),
        .i_ovf_clr(ovf_clr)
    );

    int errors = 0;
    int checks = 0;

    logic [L-1:0]  q [NF][$];
    logic [NF-1:0] ovf_m = '0;
    logic          err_m = 1'b0;

    wire [NF*L+2*NF:0] obs = {setipnum, valid, overflow, err};

    function automatic logic [31:0] base_of(input int f);
        return (f == 0) ? 32'h24000000 : 32'h28000000 + 32'(f - 1) * 32'h1000;
    endfunction

    function automatic int page_of(input logic [31:0] a);
        for (int f = 0; f < NF; f++)
            if (a >= base_of(f) && a - base_of(f) < 32'h1000) return f;
        return -1;
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [NF*L+2*NF:0] exp_all();
        logic [NF*L-1:0] s = '0;
        logic [NF-1:0]   v = '0;
        for (int k = 0; k < NF; k++) begin
            v[k] = (q[k].size() != 0);
            if (v[k]) s[k*L +: L] = q[k][0];
        end
        return {s, v, ovf_m, err_m};
    endfunction

    // One bus cycle: drive, sample combinational rdata, clock, then update the model.
    task automatic step(input logic e, input logic w, input logic [31:0] a, input logic [7:0] b,
                        input logic [63:0] wd, input logic [NF-1:0] rdy, input logic [NF-1:0] clr,
                        output logic [63:0] rd);
        int f;
        logic [31:0] off, wrd;
        logic        be_ok;
        logic [NF-1:0] setf;
        en = e; we = w; addr = {32'h0, a}; be = b; wdata = wd; ready = rdy; ovf_clr = clr;
        #1 rd = rdata;
        @(posedge clk);
        f = page_of(a);
        setf = '0;
        err_m = e && (f < 0);
        for (int k = 0; k < NF; k++)
            if (rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (e && w && f >= 0) begin
            off   = a - base_of(f);
            wrd   = a[2] ? wd[63:32] : wd[31:0];
            be_ok = a[2] ? (b[7:4] == 4'hF) : (b[3:0] == 4'hF);
            if (off == 32'h4) wrd = swap32(wrd);
            if ((off == 32'h0 || off == 32'h4) && be_ok && wrd != 0 && wrd < 64) begin
                if (q[f].size() < D) q[f].push_back(wrd[L-1:0]);
                else setf[f] = 1'b1;
            end
        end
        for (int k = 0; k < NF; k++)
            if (setf[k]) ovf_m[k] = 1'b1;
            else if (clr[k]) ovf_m[k] = 1'b0;
        #1;
        en = 1'b0; we = 1'b0; ready = '0; ovf_clr = '0;
    endtask

    task automatic idle(input logic [NF-1:0] rdy, input logic [NF-1:0] clr);
        logic [63:0] rd;
        step(1'b0, 1'b0, 32'h0, 8'h00, 64'h0, rdy, clr, rd);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] b, input logic [63:0] wd,
                      input logic [NF-1:0] rdy);
        logic [63:0] rd;
        step(1'b1, 1'b1, a, b, wd, rdy, '0, rd);
    endtask

    task automatic do_reset(input logic e, input logic [31:0] a, input logic [63:0] wd);
        rst = 1'b1; en = e; we = e; addr = {32'h0, a}; be = 8'hFF; wdata = wd;
        @(posedge clk);
        for (int k = 0; k < NF; k++) q[k].delete();
        ovf_m = '0; err_m = 1'b0;
        #1;
        rst = 1'b0; en = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 32'h0, 64'h0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", obs); end
    endtask

    task automatic test_basic();
        wr(32'h24000000, 8'h0F, 64'h5, '0);
        checks++;
        if (valid !== 4'b0001 || setipnum[L-1:0] !== 6'd5) begin
            errors++; $display("FAIL basic_push: valid=%b id=%0d want 0001/5", valid, setipnum[L-1:0]);
        end
        idle(4'b0001, '0);
        checks++;
        if (obs !== exp_all() || valid[0] !== 1'b0) begin
            errors++; $display("FAIL basic_pop: got %h want %h", obs, exp_all());
        end
    endtask

    task automatic test_file3();
        wr(32'h28002000, 8'h0F, 64'h0A, '0);
        checks++;
        if (valid !== 4'b1000 || setipnum[3*L +: L] !== 6'd10) begin
            errors++; $display("FAIL file3_le: valid=%b id=%0d want 1000/10", valid, setipnum[3*L +: L]);
        end
        wr(32'h28002004, 8'hF0, {32'h0A000000, 32'h0}, 4'b1000);
        checks++;
        if (obs !== exp_all() || setipnum[3*L +: L] !== 6'd10 || valid !== 4'b1000) begin
            errors++; $display("FAIL file3_be: got %h want %h", obs, exp_all());
        end
        idle(4'b1000, '0);
        checks++;
        if (obs !== exp_all() || valid !== 4'b0000) begin
            errors++; $display("FAIL file3_drain: got %h want %h", obs, exp_all());
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) wr(32'h28000000, 8'h0F, 64'(i), '0);
        checks++;
        if (overflow !== 4'b0010 || obs !== exp_all()) begin
            errors++; $display("FAIL overflow_set: ovf=%b got %h want %h", overflow, obs, exp_all());
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (valid[1] !== 1'b1 || setipnum[L +: L] !== 6'(i)) begin
                errors++; $display("FAIL overflow_order: valid=%b id=%0d want 1/%0d", valid[1], setipnum[L +: L], i);
            end
            idle(4'b0010, '0);
        end
        checks++;
        if (valid[1] !== 1'b0 || overflow[1] !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: valid=%b ovf=%b want 0/1", valid[1], overflow[1]);
        end
        idle('0, 4'b0010);
        checks++;
        if (overflow !== 4'b0000 || obs !== exp_all()) begin
            errors++; $display("FAIL overflow_clr: ovf=%b want 0000", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [L-1:0] want [5] = '{6'd12, 6'd13, 6'd14, 6'd7, 6'd0};
        for (int i = 11; i <= 14; i++) wr(32'h28000000, 8'h0F, 64'(i), '0);
        wr(32'h28000000, 8'h0F, 64'd7, 4'b0010);
        checks++;
        if (overflow !== 4'b0000 || obs !== exp_all()) begin
            errors++; $display("FAIL full_pop_push: got %h want %h", obs, exp_all());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid[1] !== 1'b1 || setipnum[L +: L] !== want[i]) begin
                errors++; $display("FAIL full_pop_order: id=%0d want %0d", setipnum[L +: L], want[i]);
            end
            idle(4'b0010, '0);
        end
        checks++;
        if (valid !== 4'b0000) begin errors++; $display("FAIL full_pop_empty: valid=%b want 0000", valid); end
    endtask

    task automatic test_ignored();
        logic [63:0] rd;
        wr(32'h24000000, 8'h0F, 64'd0, '0);
        wr(32'h24000000, 8'h0F, 64'd64, '0);
        wr(32'h24000004, 8'h0F, {32'h05000000, 32'h05000000}, '0);
        wr(32'h24000008, 8'h0F, 64'd5, '0);
        checks++;
        if (valid !== 4'b0000 || overflow !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL ignored_writes: valid=%b ovf=%b err=%b want 0", valid, overflow, err);
        end
        wr(32'h30000000, 8'h0F, 64'd5, '0);
        checks++;
        if (err !== 1'b1 || valid !== 4'b0000) begin errors++; $display("FAIL decode_err: err=%b want 1", err); end
        step(1'b1, 1'b0, 32'h24000000, 8'hFF, '1, '0, '0, rd);
        checks++;
        if (rd !== 64'h0 || err !== 1'b0) begin
            errors++; $display("FAIL read_zero: rdata=%h err=%b want 0/0", rd, err);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 1; i <= 3; i++) wr(32'h28001000, 8'h0F, 64'(i + 20), '0);
        checks++;
        if (valid !== 4'b0100 || obs !== exp_all()) begin
            errors++; $display("FAIL pre_reset_fill: got %h want %h", obs, exp_all());
        end
        do_reset(1'b1, 32'h28001000, 64'd9);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_midflight: got %h want 0", obs); end
    endtask

    task automatic test_random();
        logic [63:0] rd;
        logic [31:0] a, w;
        logic [7:0]  bopt [3] = '{8'hFF, 8'h0F, 8'hF0};
        logic [31:0] offs [3] = '{32'h0, 32'h4, 32'h8};
        int f;
        logic e, wr_n;
        for (int n = 0; n < 400; n++) begin
            f = $urandom_range(0, NF);
            a = (f == NF) ? (($urandom_range(0, 1) == 1) ? 32'h30000000 : 32'h28003000)
                          : base_of(f) + offs[$urandom_range(0, 2)];
            w = 32'($urandom_range(0, 70));
            if (a[3:0] == 4'h4) w = swap32(w);
            e    = ($urandom_range(0, 3) != 0);
            wr_n = ($urandom_range(0, 4) != 0);
            step(e, wr_n, a, bopt[$urandom_range(0, 2)],
                 a[2] ? {w, 32'($urandom)} : {32'($urandom), w},
                 NF'($urandom_range(0, 15)) & NF'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? NF'($urandom_range(0, 15)) : '0, rd);
            checks++;
            if (obs !== exp_all() || rd !== 64'h0) begin
                errors++; $display("FAIL random_%0d: got %h rdata %h want %h", n, obs, rd, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_file3();
        test_overflow();
        test_full_pop();
        test_ignored();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imsic_msi_queue.md
Name: imsic_msi_queue

Overview:
- Parametrised successor to the IMSIC register-map front end. Decodes MSI writes for N interrupt files (1 M-level plus N-1 S/guest files) and validates the identity.
- Each accepted write is buffered in a per-file FIFO and drained to the interrupt file over a valid/ready handshake, so back-to-back MSIs are not lost while a file is busy.
- Adds a big-endian seteipnum alias, reserved-offset handling, decode error reporting and sticky overflow flags.
- Sits between the AXI-lite slave adapter (en/we/addr/be/wdata) and the interrupt-file arrays.

Parameters:
- NR_SRC, 64: number of identities; valid IDs are 1..NR_SRC-1.
- NR_SRC_LEN, $clog2(NR_SRC): identity width.
- NR_INTP_FILES, 2: file count, range 1..64. File 0 is M-level.
- FIFO_DEPTH, 4: entries per file. Power of two, at least 2.
- M_BASE, 32'h24000000: base address of the page for file 0.
- S_BASE, 32'h28000000: base address of the page for file 1.
- FILE_STRIDE, 32'h1000: page stride for files 1 and up.
- ADDR_WIDTH, 64: bus address width. Only bits [31:0] are decoded.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_en  in  1  bus access strobe, one cycle per access.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  ADDR_WIDTH  access address.
- i_be  in  8  byte enables.
- i_wdata  in  64  write data; the 32-bit word is selected by addr[2].
- o_rdata  out  64  read data, combinational, same cycle.
- o_err  out  1  registered pulse: the previous access decoded to no file page.
- o_setipnum  out  NR_INTP_FILES x NR_SRC_LEN  head-of-FIFO identity per file.
- o_setipnum_valid  out  NR_INTP_FILES  per-file FIFO not empty.
- i_setipnum_ready  in  NR_INTP_FILES  interrupt file consumes the head entry.
- o_overflow  out  NR_INTP_FILES  sticky: a valid MSI was dropped because the FIFO was full.
- i_ovf_clr  in  NR_INTP_FILES  clears the matching o_overflow bit.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge): all FIFOs emptied (pointers and counts zeroed); o_setipnum_valid=0, o_setipnum=0, o_overflow=0, o_err=0 from the next cycle. An in-flight access in the reset cycle is discarded.
- Decode:
  - File 0 page: [M_BASE, M_BASE+FILE_STRIDE).
  - File k (k≥1) page: S_BASE+(k-1)*FILE_STRIDE plus the same span.
  - Page offset 0x000: seteipnum_le. Offset 0x004: seteipnum_be. All other offsets in a page are reserved.
  - Address outside every page: o_err=1 on the next cycle, no other effect.
- Write to seteipnum_le:
  - Requires the 4 byte enables of the addressed word all set; otherwise the write is ignored.
  - ID = word[NR_SRC_LEN-1:0]. The write is accepted only if word < NR_SRC and word != 0; otherwise it is silently ignored (no overflow, no err).
- Write to seteipnum_be: the word is byte-swapped, then handled exactly as seteipnum_le.
- Reads of any page offset: o_rdata=0, no side effects. o_rdata=0 whenever i_en&!i_we is not active.
- FIFO, per file:
  - Push on an accepted write. The pushed entry is visible on o_setipnum/valid the cycle after the write (latency 1).
  - Pop when valid & ready.
  - Full with a pop in the same cycle: the push is accepted, count unchanged.
  - Full without a pop: the push is dropped and o_overflow[k] is set the next cycle.
  - Empty: ready is ignored and the pointers do not move.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - o_setipnum holds its value while valid and not ready; the entry order is strictly FIFO.
  - Duplicate IDs are not merged.
- Overflow: set has priority over i_ovf_clr in the same cycle. Otherwise the clear takes effect the next cycle.
- Only one bus access per cycle (enforced by the adapter). The FIFOs of different files are fully independent.

Test Plan:
- Reset, then write 0x00000005 to 0x24000000 → next cycle valid[0]=1, setipnum[0]=5. Assert ready[0] → valid[0]=0 the following cycle.
- NR_INTP_FILES=4: write 0x0A to 0x28002000 → only file 3 valid with ID 10. Write 0x0A000000 to 0x28002004 (BE) → file 3 queues a second ID 10.
- Hold ready[1]=0 and write IDs 1..5 to 0x28000000 (depth 4) → IDs 1-4 queued, 5 dropped, overflow[1]=1. Drain → order 1,2,3,4. Pulse i_ovf_clr[1] → overflow[1]=0.
- FIFO full with ready=1 and a write of ID 7 in the same cycle → count stays 4 and ID 7 appears after the existing entries; no overflow.
- Write ID 0 and ID 64 (NR_SRC=64); write with be=0x0F into word 1 → no push. Write to 0x30000000 → o_err=1 for one cycle. Read 0x24000000 → rdata=0.
- Assert i_rst with 3 entries queued and a write in the same cycle → all valid=0, no entry survives.
